// File: rtl/dot_matrix_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dot_matrix_pkg
// Description : Shared constants, FSM state type and row-select decode for
//               the dot-matrix scheduler.
// Contents    : ROWS, COLS   - frame buffer geometry (8 x 8)
//               state_t      - scheduler FSM states (IDLE, CLEAR)
//               row_pattern  - row index -> active-low one-cold row select
// Revision    : 1.0 - initial release
// ============================================================================
package dot_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Row 0 drives the MSB low, row 7 drives the LSB low.
    function automatic logic [COLS-1:0] row_pattern(input logic [2:0] idx);
        return ~(8'h80 >> idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dot_rr_arbiter
// Description : Two-requester round-robin arbiter. A requester is eligible
//               while it requests and its grant is low; on a tie the one not
//               granted most recently wins. Grants are registered one-cycle
//               pulses; the win signals are the same decision, combinational,
//               so the caller can commit its write on the granting edge.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               en                - arbitration allowed this cycle
//               req_a, req_b      - raw requests (a = favoured after reset)
//               win_a, win_b      - combinational decision for this edge
//               gnt_a, gnt_b      - registered grant pulses
// Revision    : 1.0 - initial release
// ============================================================================
module dot_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic win_a,
    output logic win_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_a;   // 1 when a received the most recent grant
    logic elig_a;
    logic elig_b;

    always_comb begin
        elig_a = req_a & ~gnt_a;
        elig_b = req_b & ~gnt_b;
        win_a  = en & elig_a & (~elig_b | ~last_a);
        win_b  = en & elig_b & ~win_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            last_a <= 1'b0;
        end else begin
            gnt_a <= win_a;
            gnt_b <= win_b;
            if (win_a) begin
                last_a <= 1'b1;
            end else if (win_b) begin
                last_a <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dot_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_scheduler
// Description : 8x8 LED dot-matrix frame buffer with two arbitrated writers
//               (keypad painter: OR-merge, animation: overwrite), an 8-cycle
//               whole-buffer clear, and a row scanner driven by scan_tick.
// Ports       : div_clk            - clock
//               rst                - asynchronous active-low reset
//               scan_tick          - advance the row scan
//               kp_req/row/data/gnt- keypad painter write port (OR-merge)
//               an_req/row/data/gnt- animation write port (overwrite)
//               clr                - start a frame clear
//               dot_row            - active-low one-cold row select
//               dot_col            - active-high column data
//               busy               - clear in progress
// Config      : DOT_BLANK_EN - blank dot_col for one cycle after each
//               scan_tick before showing the row data.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_matrix_scheduler
    import dot_matrix_pkg::*;
(
    input  logic            div_clk,
    input  logic            rst,
    input  logic            scan_tick,
    input  logic            kp_req,
    input  logic [2:0]      kp_row,
    input  logic [7:0]      kp_data,
    output logic            kp_gnt,
    input  logic            an_req,
    input  logic [2:0]      an_row,
    input  logic [7:0]      an_data,
    output logic            an_gnt,
    input  logic            clr,
    output logic [7:0]      dot_row,
    output logic [7:0]      dot_col,
    output logic            busy
);

    logic [COLS-1:0] frame [ROWS];
    state_t          state;
    state_t          state_next;
    logic [2:0]      clr_idx;
    logic [2:0]      scan_idx;
    logic            arb_en;
    logic            kp_win;
    logic            an_win;

    // ---------------- FSM ----------------
    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (clr_idx == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Held at 0 in IDLE so each clear starts at row 0; wraps 7->0 on exit.
    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            clr_idx <= 3'd0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 3'd1;
        end else begin
            clr_idx <= 3'd0;
        end
    end

    // ---------------- Arbiter ----------------
    dot_rr_arbiter u_arb (
        .clk   (div_clk),
        .rst_n (rst),
        .en    (arb_en),
        .req_a (kp_req),
        .req_b (an_req),
        .win_a (kp_win),
        .win_b (an_win),
        .gnt_a (kp_gnt),
        .gnt_b (an_gnt)
    );

    // ---------------- Frame buffer ----------------
    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++) begin
                frame[i] <= '0;
            end
        end else if (state == CLEAR) begin
            frame[clr_idx] <= '0;
        end else if (kp_win) begin
            frame[kp_row] <= frame[kp_row] | kp_data;
        end else if (an_win) begin
            frame[an_row] <= an_data;
        end
    end

    // ---------------- Row scanner ----------------
    // frame[] is read with its pre-edge value, so a write landing on the
    // scanned row in the same cycle shows up on the next pass.
`ifdef DOT_BLANK_EN
    logic            blank_pend;
    logic [COLS-1:0] col_hold;

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            scan_idx   <= 3'd0;
            dot_row    <= 8'hFF;
            dot_col    <= 8'h00;
            blank_pend <= 1'b0;
            col_hold   <= 8'h00;
        end else if (scan_tick) begin
            scan_idx   <= scan_idx + 3'd1;
            dot_row    <= row_pattern(scan_idx);
            dot_col    <= 8'h00;
            col_hold   <= frame[scan_idx];
            blank_pend <= 1'b1;
        end else if (blank_pend) begin
            dot_col    <= col_hold;
            blank_pend <= 1'b0;
        end
    end
`else
    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            scan_idx <= 3'd0;
            dot_row  <= 8'hFF;
            dot_col  <= 8'h00;
        end else if (scan_tick) begin
            scan_idx <= scan_idx + 3'd1;
            dot_row  <= row_pattern(scan_idx);
            dot_col  <= frame[scan_idx];
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/dot_matrix_scheduler.md
DOT_MATRIX_SCHEDULER -- requirements
Module: dot_matrix_scheduler

Interface
REQ-001 The block SHALL have port div_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port scan_tick, input, 1 bit: one-cycle strobe that advances the display row scan.
REQ-004 The block SHALL have ports kp_req (in, 1), kp_row (in, 3), kp_data (in, 8) and kp_gnt (out, 1): the keypad painter write requester, which writes in OR-merge mode.
REQ-005 The block SHALL have ports an_req (in, 1), an_row (in, 3), an_data (in, 8) and an_gnt (out, 1): the animation write requester, which writes in overwrite mode.
REQ-006 The block SHALL have port clr, input, 1 bit: one-cycle strobe that clears the whole frame buffer.
REQ-007 The block SHALL have port dot_row, output, 8 bits: active-low one-cold row select.
REQ-008 The block SHALL have port dot_col, output, 8 bits: active-high column data for the selected row.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a clear is in progress.

Function
REQ-010 The block SHALL hold an 8x8 frame buffer of eight 8-bit rows.
REQ-011 The FSM SHALL have two states, IDLE and CLEAR; requests and clr SHALL be sampled only in IDLE.
REQ-012 In IDLE, clr=1 SHALL enter CLEAR on the next edge, taking priority over both requesters; no grant SHALL issue that cycle.
REQ-013 CLEAR SHALL last exactly 8 cycles, zeroing row 0 through row 7 one row per cycle, and SHALL then return to IDLE; busy SHALL be 1 for exactly those 8 cycles.
REQ-014 In CLEAR, clr SHALL be ignored and no grant SHALL issue; pending requests SHALL wait.
REQ-015 A requester SHALL be eligible when its req=1 and its gnt is currently 0.
REQ-016 If exactly one requester is eligible, it SHALL be granted; if both are eligible, the one not granted last SHALL win (round-robin).
REQ-017 The round-robin pointer SHALL favour kp after reset.
REQ-018 A grant SHALL be a registered one-cycle pulse asserted on the edge after sampling; the buffer row SHALL take its new value on that same edge.
REQ-019 A kp write SHALL set buf[kp_row] to buf[kp_row] | kp_data; an an write SHALL set buf[an_row] to an_data.
REQ-020 At most one write SHALL occur per cycle; kp_gnt and an_gnt SHALL never be high together.
REQ-021 Each requester SHALL hold row/data stable while req=1 until it sees gnt.
REQ-022 On each scan_tick, the row counter SHALL increment, wrapping 7 to 0.
REQ-023 On each scan_tick, dot_col SHALL load buf[row counter] using the counter value before the increment.
REQ-024 On each scan_tick, dot_row SHALL load the active-low pattern for that row: row 0 = 8'b01111111 through row 7 = 8'b11111110.
REQ-025 If a write to the row being scanned coincides with scan_tick, dot_col SHALL show the pre-write value.
REQ-026 Row scanning SHALL continue unaffected during CLEAR.

Reset
REQ-027 Asserting rst SHALL immediately set all buffer rows to 0, the FSM to IDLE, the row counter to 0 and the round-robin pointer to kp.
REQ-028 Asserting rst SHALL immediately set dot_row=8'hFF, dot_col=8'h00, kp_gnt=0, an_gnt=0 and busy=0.
REQ-029 Reset mid-CLEAR SHALL abort the clear; after release the block SHALL be in IDLE with an all-zero buffer.

Configuration
REQ-030 When DOT_BLANK_EN is defined, dot_col SHALL be forced to 8'h00 for the one cycle after each scan_tick and SHALL show the row data from the following cycle, for ghosting suppression.
REQ-031 When DOT_BLANK_EN is undefined, dot_col SHALL update on the scan_tick edge with no blanking cycle.

Structure
REQ-032 Package dot_matrix_pkg SHALL hold the ROWS=8 and COLS=8 constants, the FSM state type (IDLE, CLEAR) and the row-index-to-active-low-pattern function.
REQ-033 The two-requester round-robin arbiter SHALL be a sub-module named dot_rr_arbiter.

Verification
REQ-034 Reset, then scan_tick for 8 ticks -> dot_row steps 7F, BF, DF, EF, F7, FB, FD, FE, then wraps to 7F; dot_col=00 throughout.
REQ-035 kp writes row 6 with C0, then kp writes row 6 with 30 -> buf[6]=F0; an writes row 6 with 01 -> buf[6]=01.
REQ-036 kp_req and an_req held high together for 4 cycles after reset -> grants alternate kp, an, kp, an, and the two grants are never high together.
REQ-037 clr asserted with kp_req high -> busy is high for exactly 8 cycles, kp_gnt stays 0 during them, all rows read 0, and kp_gnt pulses on the cycle after busy falls.
REQ-038 rst asserted on the 4th CLEAR cycle -> all outputs return to reset values, and after release clr works normally.
